// File: rtl/strided_scatter_writer.sv
// strided_scatter_writer
// Moves one processed block from the result buffer into the image memory.
// The result buffer is read linearly (word n at address n). Each word is written
// to base + pass + STRIDE*step, which is the column-interleaved order used by the
// strided reader, so write n lands at base + n/STEPS + STRIDE*(n%STEPS) (mod 2^AW_A).
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     1-cycle pulse that begins a block (ignored while a block is active)
//   base      destination base address, sampled when start is accepted
//   addrb     result-buffer read address
//   enb       result-buffer read enable (data on doutb one cycle later)
//   doutb     result-buffer read data
//   addra     image-memory write address
//   dina      image-memory write data
//   wea       write valid; a write completes on wea & wr_ready
//   wr_ready  image memory accepts the write this cycle
//   busy      block transfer in progress
//   done      1-cycle pulse after the last write of the block completes
module strided_scatter_writer #(
    parameter int STRIDE = 4,
    parameter int STEPS  = 13,
    parameter int AW_A   = 11,
    parameter int AW_B   = 9,
    parameter int DW     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW_A-1:0] base,
    output logic [AW_B-1:0] addrb,
    output logic            enb,
    input  logic [DW-1:0]   doutb,
    output logic [AW_A-1:0] addra,
    output logic [DW-1:0]   dina,
    output logic            wea,
    input  logic            wr_ready,
    output logic            busy,
    output logic            done
);

    localparam int N  = STRIDE * STEPS;
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state_q,      state_d;
    logic [AW_A-1:0] base_q,       base_d;
    logic [AW_B-1:0] rd_idx_q,     rd_idx_d;
    logic [PW-1:0]   pass_q,       pass_d;
    logic [SW-1:0]   step_q,       step_d;
    logic            inflight_q,   inflight_d;
    logic            out_valid_q,  out_valid_d;
    logic [DW-1:0]   out_data_q,   out_data_d;
    logic            skid_valid_q, skid_valid_d;
    logic [DW-1:0]   skid_data_q,  skid_data_d;

    logic       wr_fire;
    logic       last_wr;
    logic       rd_en;
    logic [1:0] occ;
    logic       room;

    assign wr_fire = out_valid_q & wr_ready;
    assign last_wr = wr_fire && (pass_q == PW'(STRIDE - 1)) && (step_q == SW'(STEPS - 1));

    // Words held or on their way: output register, skid register, read in flight.
    // A new read is allowed only if at most one word remains after this cycle's
    // write, so the total never exceeds two.
    assign occ  = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q};
    assign room = (occ - {1'b0, wr_fire}) <= 2'd1;

    // Word 0 is read in the cycle start is accepted so the first write appears
    // two cycles after the start pulse.
    assign rd_en = ((state_q == S_IDLE) && start) || ((state_q == S_RUN) && room);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        rd_idx_d     = rd_idx_q;
        pass_d       = pass_q;
        step_d       = step_q;
        inflight_d   = rd_en;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (rd_en) begin
            rd_idx_d = rd_idx_q + AW_B'(1);
        end

        // Write-side address counters.
        if (wr_fire) begin
            if (step_q == SW'(STEPS - 1)) begin
                step_d = '0;
                pass_d = pass_q + PW'(1);
            end else begin
                step_d = step_q + SW'(1);
            end
        end

        // Output/skid data path. The skid register only fills while the output
        // register is occupied, and drains into it first when it frees.
        if (!out_valid_q || wr_fire) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = inflight_q;
                skid_data_d  = doutb;
            end else if (inflight_q) begin
                out_valid_d = 1'b1;
                out_data_d  = doutb;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (inflight_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = doutb;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    base_d  = base;
                end
            end
            S_RUN: begin
                if (rd_en && (rd_idx_q == AW_B'(N - 1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_wr) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                rd_idx_d = '0;
                pass_d   = '0;
                step_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            rd_idx_q     <= '0;
            pass_q       <= '0;
            step_q       <= '0;
            inflight_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            rd_idx_q     <= rd_idx_d;
            pass_q       <= pass_d;
            step_q       <= step_d;
            inflight_q   <= inflight_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign addrb = rd_idx_q;
    assign enb   = rd_en;
    assign wea   = out_valid_q;
    assign dina  = out_data_q;
    assign addra = base_q + AW_A'(pass_q) + AW_A'(STRIDE) * AW_A'(step_q);
    assign busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done  = (state_q == S_DONE);

endmodule
